// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C LED host write engine.
// Holds the FSM state enum, ACK/NACK/R-W bit values and quarter phases.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK,
    LOAD,
    DATA,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider: one-cycle strobe every CLK_DIV clocks.
// Counter is cleared while disabled and parked at zero while held.
module i2c_tick_gen #(
  parameter int CLK_DIV = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && !hold && (cnt == LAST);

  // Free-running modulo-CLK_DIV count while enabled.
  always_ff @(posedge clk) begin
    if (reset || !en || hold) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_led_host.sv
// I2C controller write engine: START, addr+W, byte stream, STOP.
// Optional SCL clock stretching via I2C_CLK_STRETCH_EN.
module i2c_led_host
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_o,
  input  logic       scl_i,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o
);

  state_t     state;
  quarter_t   q;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       last_q;
  logic       nack_q;
  logic       ack_bit;
  logic       tick;
  logic       tick_en;
  logic       hold;

  // SCL is parked low in LOAD, so the divider restarts cleanly.
  assign tick_en = busy_o && (state != LOAD);

`ifdef I2C_CLK_STRETCH_EN
  logic in_bit;
  assign in_bit = (state == ADDR) || (state == DATA)
               || (state == ACK);
  assign hold   = in_bit && (q == Q2) && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold       = 1'b0;
`endif

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .hold  (hold),
    .tick  (tick)
  );

  // Transaction FSM; every bus-facing output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      q            <= Q0;
      bit_cnt      <= '0;
      shreg        <= '0;
      last_q       <= 1'b0;
      nack_q       <= 1'b0;
      ack_bit      <= 1'b0;
      scl_o        <= 1'b1;
      sda_o        <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      nack_o       <= 1'b0;
      data_ready_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            shreg   <= {addr_i, I2C_WRITE};
            last_q  <= 1'b0;
            nack_q  <= 1'b0;
            nack_o  <= 1'b0;
            busy_o  <= 1'b1;
            sda_o   <= 1'b0;
            q       <= Q0;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            if (q == Q0) begin
              q <= Q1;
            end else begin
              q     <= Q0;
              scl_o <= 1'b0;
              sda_o <= shreg[7];
              state <= ADDR;
            end
          end
        end
        ADDR, DATA, ACK: begin
          if (tick) begin
            unique case (q)
              Q0: q <= Q1;
              Q1: begin
                q     <= Q2;
                scl_o <= 1'b1;
              end
              Q2: begin
                q       <= Q3;
                ack_bit <= sda_i;
              end
              Q3: begin
                q     <= Q0;
                scl_o <= 1'b0;
                if (state != ACK) begin
                  shreg   <= {shreg[6:0], 1'b0};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                    sda_o <= 1'b1;
                    state <= ACK;
                  end else begin
                    sda_o <= shreg[6];
                  end
                end else if (ack_bit != I2C_ACK
                             || last_q) begin
                  nack_q  <= nack_q
                           | (ack_bit == I2C_NACK);
                  sda_o   <= 1'b0;
                  bit_cnt <= '0;
                  state   <= STOP;
                end else begin
                  sda_o        <= 1'b1;
                  data_ready_o <= 1'b1;
                  state        <= LOAD;
                end
              end
            endcase
          end
        end
        LOAD: begin
          if (data_valid_i && data_ready_o) begin
            shreg        <= data_i;
            last_q       <= data_last_i;
            data_ready_o <= 1'b0;
            sda_o        <= data_i[7];
            q            <= Q0;
            state        <= DATA;
          end
        end
        STOP: begin
          if (tick) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd1) scl_o <= 1'b1;
            if (bit_cnt == 3'd3) sda_o <= 1'b1;
            if (bit_cnt == 3'd5) begin
              done_o <= 1'b1;
              nack_o <= nack_q;
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
